serial_sub_ctrl: RTL and testbench

- Bit-serial subtraction sequencer that drives one external 1-bit full-subtractor cell. The cell has enable, A, B and borrow-in inputs, and Y and borrow-out outputs.
- Accepts two W-bit operands, feeds them to the cell LSB-first, one bit per clock, and carries the borrow in a register between bits.
- Assembles the W-bit difference and the final borrow, then signals completion.
- Sits directly upstream of the full-subtractor cell and also consumes that cell's outputs.

---
 rtl/serial_sub_ctrl.sv | 134 +++++++++++++
 tb/tb_serial_sub_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtraction sequencer driving an external 1-bit full-subtractor cell.
// Operands are fed LSB-first; the borrow is carried in a register between bits.
module serial_sub_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         bin_init,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_final,
    output logic         fs_en,
    output logic         fs_a,
    output logic         fs_b,
    output logic         fs_bin,
    input  logic         fs_y,
    input  logic         fs_bout
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]   b_sh_q, b_sh_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   diff_q, diff_d;
    logic           brw_q, brw_d;
    logic           bfin_q, bfin_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_bit;

    assign last_bit = (cnt_q == CW'(W - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        fs_en  = (state_q == RUN);
        fs_a   = 1'b0;
        fs_b   = 1'b0;
        fs_bin = 1'b0;
        if (state_q == RUN) begin
            fs_a   = a_sh_q[0];
            fs_b   = b_sh_q[0];
            fs_bin = brw_q;
        end
    end

    // The cell result arrives combinationally, so the completed difference on
    // the last bit is the shifted result register with fs_y placed at the MSB.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        diff_d = diff_q;
        brw_d  = brw_q;
        bfin_d = bfin_q;
        cnt_d  = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d = a_in;
                    b_sh_d = b_in;
                    brw_d  = bin_init;
                    cnt_d  = '0;
                end
            end
            RUN: begin
                a_sh_d       = a_sh_q >> 1;
                b_sh_d       = b_sh_q >> 1;
                res_d        = res_q >> 1;
                res_d[W-1]   = fs_y;
                brw_d        = fs_bout;
                cnt_d        = cnt_q + CW'(1);
                if (last_bit) begin
                    diff_d = res_d;
                    bfin_d = fs_bout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            res_q  <= '0;
            diff_q <= '0;
            brw_q  <= 1'b0;
            bfin_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            res_q  <= res_d;
            diff_q <= diff_d;
            brw_q  <= brw_d;
            bfin_q <= bfin_d;
            cnt_q  <= cnt_d;
        end
    end

    assign diff         = diff_q;
    assign borrow_final = bfin_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Testbench for serial_sub_ctrl: W=8 and W=1 instances, each paired with a
// behavioural full-subtractor cell; results are checked against a queue of expectations.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    logic       start, binInit, busy, done, borrowFinal;
    logic [7:0] aIn, bIn, diff;
    logic       fsEn, fsA, fsB, fsBin, fsY, fsBout;

    logic       w1Start, w1Bin, w1Busy, w1Done, w1Borrow;
    logic [0:0] w1A, w1B, w1Diff;
    logic       w1FsEn, w1FsA, w1FsB, w1FsBin, w1FsY, w1FsBout;

    assign fsY      = fsA ^ fsB ^ fsBin;
    assign fsBout   = (~fsA & fsB) | (~fsA & fsBin) | (fsB & fsBin);
    assign w1FsY    = w1FsA ^ w1FsB ^ w1FsBin;
    assign w1FsBout = (~w1FsA & w1FsB) | (~w1FsA & w1FsBin) | (w1FsB & w1FsBin);

    serial_sub_ctrl #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(aIn), .b_in(bIn),
        .bin_init(binInit), .busy(busy), .done(done), .diff(diff),
        .borrow_final(borrowFinal), .fs_en(fsEn), .fs_a(fsA), .fs_b(fsB),
        .fs_bin(fsBin), .fs_y(fsY), .fs_bout(fsBout)
    );

    serial_sub_ctrl #(.W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(w1Start), .a_in(w1A), .b_in(w1B),
        .bin_init(w1Bin), .busy(w1Busy), .done(w1Done), .diff(w1Diff),
        .borrow_final(w1Borrow), .fs_en(w1FsEn), .fs_a(w1FsA), .fs_b(w1FsB),
        .fs_bin(w1FsBin), .fs_y(w1FsY), .fs_bout(w1FsBout)
    );

    int         checks = 0;
    int         errors = 0;
    int         doneCount = 0;
    int         enCount = 0;
    logic [8:0] sb[$];
    logic [8:0] sbExp;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) doneCount++;
            if (fsEn) enCount++;
        end
    end

    // Reference: {borrow, diff} from plain integer arithmetic.
    function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        int d;
        logic [7:0] low;
        d   = int'(a) - int'(b) - int'(bin);
        low = d[7:0];
        return {(d < 0), low};
    endfunction

    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic bin);
        aIn = a; bIn = b; binInit = bin; start = 1'b1;
        sb.push_back(model8(a, b, bin));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        #11;
        checks++;
        if ({busy, done, diff, borrowFinal, fsEn, fsA, fsB, fsBin} !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_w8: outputs=%h expected 0",
                     {busy, done, diff, borrowFinal, fsEn, fsA, fsB, fsBin});
        end
        checks++;
        if ({w1Busy, w1Done, w1Diff, w1Borrow, w1FsEn, w1FsA, w1FsB, w1FsBin} !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_w1: outputs=%h expected 0",
                     {w1Busy, w1Done, w1Diff, w1Borrow, w1FsEn, w1FsA, w1FsB, w1FsBin});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        launch(8'h5A, 8'h33, 1'b0);
        wait_done(cyc);
        checks++;
        if (!done || cyc != 8) begin
            errors++;
            $display("[TB] FAIL basic_latency: done=%b after %0d edges, expected done=1 after 8", done, cyc);
        end
        sbExp = sb.pop_front();
        checks++;
        if ({borrowFinal, diff} !== sbExp) begin
            errors++;
            $display("[TB] FAIL basic_result: got %h expected %h", {borrowFinal, diff}, sbExp);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h27 || borrowFinal !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_hold: busy=%b done=%b diff=%h bf=%b expected 0 0 27 0",
                     busy, done, diff, borrowFinal);
        end
    endtask

    task automatic test_borrow();
        int cyc, enBase;
        enBase = enCount;
        launch(8'h00, 8'h01, 1'b0);
        wait_done(cyc);
        sbExp = sb.pop_front();
        checks++;
        if (!done || {borrowFinal, diff} !== sbExp || sbExp !== 9'h1FF) begin
            errors++;
            $display("[TB] FAIL borrow_result: done=%b got %h expected 1ff", done, {borrowFinal, diff});
        end
        @(posedge clk); #1;
        checks++;
        if (enCount - enBase != 8) begin
            errors++;
            $display("[TB] FAIL borrow_fs_en_cycles: got %0d expected 8", enCount - enBase);
        end
    endtask

    task automatic test_bin_init();
        int cyc;
        launch(8'h10, 8'h0F, 1'b1);
        wait_done(cyc);
        sbExp = sb.pop_front();
        checks++;
        if (!done || {borrowFinal, diff} !== 9'h000) begin
            errors++;
            $display("[TB] FAIL bin_init_exact: done=%b got %h expected 000", done, {borrowFinal, diff});
        end
        @(posedge clk); #1;
        launch(8'h00, 8'h00, 1'b1);
        wait_done(cyc);
        sbExp = sb.pop_front();
        checks++;
        if (!done || {borrowFinal, diff} !== sbExp) begin
            errors++;
            $display("[TB] FAIL bin_init_wrap: done=%b got %h expected %h", done, {borrowFinal, diff}, sbExp);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int cyc, doneBase;
        doneBase = doneCount;
        launch(8'hC3, 8'h41, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        aIn = 8'hFF; bIn = 8'h00; binInit = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(cyc);
        checks++;
        if (!done || cyc != 4) begin
            errors++;
            $display("[TB] FAIL ignore_latency: done=%b after %0d edges, expected done=1 after 4", done, cyc);
        end
        sbExp = sb.pop_front();
        checks++;
        if ({borrowFinal, diff} !== sbExp) begin
            errors++;
            $display("[TB] FAIL ignore_result: got %h expected %h", {borrowFinal, diff}, sbExp);
        end
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (doneCount - doneBase != 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignore_single_done: pulses=%0d busy=%b expected 1 0", doneCount - doneBase, busy);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        aIn = 8'h80; bIn = 8'h7F; binInit = 1'b0; start = 1'b1;
        sb.push_back(model8(8'h80, 8'h7F, 1'b0));
        sb.push_back(model8(8'h80, 8'h7F, 1'b0));
        @(posedge clk); #1;
        wait_done(cyc);
        sbExp = sb.pop_front();
        checks++;
        if (!done || cyc != 8 || {borrowFinal, diff} !== sbExp) begin
            errors++;
            $display("[TB] FAIL b2b_first: done=%b edges=%0d got %h expected 1/8/%h", done, cyc, {borrowFinal, diff}, sbExp);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || fsEn !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_idle_gap: busy=%b fs_en=%b expected 0 0", busy, fsEn);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || fsEn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_restart: busy=%b fs_en=%b expected 1 1", busy, fsEn);
        end
        wait_done(cyc);
        start = 1'b0;
        sbExp = sb.pop_front();
        checks++;
        if (!done || cyc != 8 || {borrowFinal, diff} !== sbExp) begin
            errors++;
            $display("[TB] FAIL b2b_second: done=%b edges=%0d got %h expected 1/8/%h", done, cyc, {borrowFinal, diff}, sbExp);
        end
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_stop: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc, doneBase;
        launch(8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #4;
        doneBase = doneCount;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({busy, done, fsEn, diff, borrowFinal} !== 11'd0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: busy=%b done=%b fs_en=%b diff=%h bf=%b expected all 0",
                     busy, done, fsEn, diff, borrowFinal);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        checks++;
        if (doneCount != doneBase || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: pulses=%0d busy=%b expected 0 0", doneCount - doneBase, busy);
        end
        launch(8'h9C, 8'h2D, 1'b1);
        wait_done(cyc);
        sbExp = sb.pop_front();
        checks++;
        if (!done || cyc != 8 || {borrowFinal, diff} !== 9'h06E) begin
            errors++;
            $display("[TB] FAIL abort_recover: done=%b edges=%0d got %h expected 1/8/06e", done, cyc, {borrowFinal, diff});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_w1();
        int cyc;
        w1A = 1'b0; w1B = 1'b1; w1Bin = 1'b0; w1Start = 1'b1;
        @(posedge clk); #1;
        w1Start = 1'b0;
        cyc = 0;
        while (!w1Done && cyc < 10) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (!w1Done || cyc != 1 || w1Diff !== 1'b1 || w1Borrow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL w1_borrow: done=%b edges=%0d diff=%b bf=%b expected 1/1/1/1", w1Done, cyc, w1Diff, w1Borrow);
        end
        @(posedge clk); #1;
        w1A = 1'b1; w1B = 1'b0; w1Bin = 1'b1; w1Start = 1'b1;
        @(posedge clk); #1;
        w1Start = 1'b0;
        cyc = 0;
        while (!w1Done && cyc < 10) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (!w1Done || cyc != 1 || w1Diff !== 1'b0 || w1Borrow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL w1_exact: done=%b edges=%0d diff=%b bf=%b expected 1/1/0/0", w1Done, cyc, w1Diff, w1Borrow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int cyc;
        logic [7:0] a, b;
        logic bin;
        for (int i = 0; i < 1000; i++) begin
            a   = 8'($urandom_range(0, 255));
            b   = 8'($urandom_range(0, 255));
            bin = 1'($urandom_range(0, 1));
            launch(a, b, bin);
            wait_done(cyc);
            sbExp = sb.pop_front();
            checks++;
            if (!done || {borrowFinal, diff} !== sbExp) begin
                errors++;
                $display("[TB] FAIL random_%0d: a=%h b=%h bin=%b done=%b got %h expected %h",
                         i, a, b, bin, done, {borrowFinal, diff}, sbExp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0; aIn = '0; bIn = '0; binInit = 1'b0;
        w1Start = 1'b0; w1A = '0; w1B = '0; w1Bin = 1'b0;
        #1 rst_n = 1'b0;
        test_reset();
        test_basic();
        test_borrow();
        test_bin_init();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
        test_w1();
        test_random();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
